// File: rtl/aes_round_sequencer.sv
// Control FSM for an iterative AES-128 round datapath: issues load, key-schedule and
// round strobes with round index and rcon, and waits on the datapath ready handshake.
module aes_round_sequencer #(
  parameter int NR = 10,
  parameter int CW = 4
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_ni,
  input  logic          start_i,
  input  logic          decrypt_i,
  input  logic          abort_i,
  input  logic          dp_ready_i,
  output logic          busy_o,
  output logic          done_o,
  output logic          aborted_o,
  output logic          load_o,
  output logic          round_step_o,
  output logic [1:0]    round_type_o,
  output logic          key_step_o,
  output logic          key_inv_o,
  output logic          inv_o,
  output logic [CW-1:0] round_o,
  output logic [7:0]    rcon_o
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    KEYEXP = 3'd2,
    INIT   = 3'd3,
    ROUND  = 3'd4,
    FINAL  = 3'd5,
    DONE   = 3'd6
  } state_t;

  localparam logic [CW-1:0] ROUND_ZERO   = '0;
  localparam logic [CW-1:0] ROUND_ONE    = CW'(1);
  localparam logic [CW-1:0] ROUND_PENULT = CW'(NR - 1);
  localparam logic [CW-1:0] ROUND_LAST   = CW'(NR);

  localparam logic [1:0] TYPE_INIT  = 2'b00;
  localparam logic [1:0] TYPE_FULL  = 2'b01;
  localparam logic [1:0] TYPE_FINAL = 2'b10;

  state_t        state_reg, state_next;
  logic [CW-1:0] round_reg, round_next;
  logic          inv_reg, inv_next;
  logic          aborted_reg, aborted_next;
  logic          abort_take;
  logic          round_is_last;

  function automatic logic [7:0] rcon_of(input logic [31:0] k);
    logic [7:0] r;
    case (k)
      32'd1:   r = 8'h01;
      32'd2:   r = 8'h02;
      32'd3:   r = 8'h04;
      32'd4:   r = 8'h08;
      32'd5:   r = 8'h10;
      32'd6:   r = 8'h20;
      32'd7:   r = 8'h40;
      32'd8:   r = 8'h80;
      32'd9:   r = 8'h1b;
      32'd10:  r = 8'h36;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_reg   <= IDLE;
      round_reg   <= '0;
      inv_reg     <= 1'b0;
      aborted_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      round_reg   <= round_next;
      inv_reg     <= inv_next;
      aborted_reg <= aborted_next;
    end
  end

  // Abort is honoured in every busy state except DONE, where the operation has already finished.
  assign abort_take    = abort_i && (state_reg != IDLE) && (state_reg != DONE);
  assign round_is_last = inv_reg ? (round_reg == ROUND_ONE) : (round_reg == ROUND_PENULT);

  always_comb begin
    state_next   = state_reg;
    round_next   = round_reg;
    inv_next     = inv_reg;
    aborted_next = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start_i) begin
          inv_next   = decrypt_i;
          round_next = ROUND_ZERO;
          state_next = LOAD;
        end
      end
      LOAD: begin
        if (inv_reg) begin
          round_next = ROUND_ONE;
          state_next = KEYEXP;
        end else begin
          round_next = ROUND_ZERO;
          state_next = INIT;
        end
      end
      KEYEXP: begin
        if (dp_ready_i) begin
          if (round_reg == ROUND_LAST) begin
            state_next = INIT;
          end else begin
            round_next = round_reg + ROUND_ONE;
          end
        end
      end
      INIT: begin
        if (dp_ready_i) begin
          round_next = inv_reg ? ROUND_PENULT : ROUND_ONE;
          state_next = ROUND;
        end
      end
      ROUND: begin
        if (dp_ready_i) begin
          if (round_is_last) begin
            state_next = FINAL;
          end else if (inv_reg) begin
            round_next = round_reg - ROUND_ONE;
          end else begin
            round_next = round_reg + ROUND_ONE;
          end
        end
      end
      FINAL: begin
        if (dp_ready_i) begin
          state_next = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
    if (abort_take) begin
      state_next   = IDLE;
      round_next   = ROUND_ZERO;
      aborted_next = 1'b1;
    end
  end

  always_comb begin
    done_o       = 1'b0;
    load_o       = 1'b0;
    round_step_o = 1'b0;
    round_type_o = TYPE_INIT;
    key_step_o   = 1'b0;
    key_inv_o    = 1'b0;
    round_o      = ROUND_ZERO;
    rcon_o       = 8'h00;
    case (state_reg)
      LOAD: begin
        load_o = 1'b1;
      end
      KEYEXP: begin
        key_step_o = 1'b1;
        round_o    = round_reg;
        rcon_o     = rcon_of(32'(round_reg));
      end
      INIT: begin
        round_step_o = 1'b1;
        round_o      = inv_reg ? ROUND_LAST : ROUND_ZERO;
      end
      ROUND: begin
        round_step_o = 1'b1;
        key_step_o   = 1'b1;
        round_type_o = TYPE_FULL;
        key_inv_o    = inv_reg;
        round_o      = round_reg;
        // The inverse key step undoes round r+1's expansion, so it needs that round's rcon.
        rcon_o       = inv_reg ? rcon_of(32'(round_reg) + 32'd1) : rcon_of(32'(round_reg));
      end
      FINAL: begin
        round_step_o = 1'b1;
        key_step_o   = 1'b1;
        round_type_o = TYPE_FINAL;
        key_inv_o    = inv_reg;
        round_o      = inv_reg ? ROUND_ZERO : ROUND_LAST;
        rcon_o       = inv_reg ? rcon_of(32'd1) : rcon_of(32'(NR));
      end
      DONE: begin
        done_o = 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign busy_o    = (state_reg != IDLE);
  assign aborted_o = aborted_reg;
  assign inv_o     = inv_reg;

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Scoreboard bench for aes_round_sequencer: each start pushes the expected strobe
// sequence, and a negedge monitor pops and compares it as the sequencer emits events.
module tb_aes_round_sequencer;

  localparam logic [7:0] RCON_TAB [11] = '{8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                          8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start_i, decrypt_i, abort_i, dp_ready_i;
  logic       busy_o, done_o, aborted_o, load_o, round_step_o, key_step_o, key_inv_o, inv_o;
  logic [1:0] round_type_o;
  logic [3:0] round_o;
  logic [7:0] rcon_o;

  aes_round_sequencer #(.NR(10), .CW(4)) dut (
    .wb_clk_i    (clk),
    .wb_rst_ni   (rst_n),
    .start_i     (start_i),
    .decrypt_i   (decrypt_i),
    .abort_i     (abort_i),
    .dp_ready_i  (dp_ready_i),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .aborted_o   (aborted_o),
    .load_o      (load_o),
    .round_step_o(round_step_o),
    .round_type_o(round_type_o),
    .key_step_o  (key_step_o),
    .key_inv_o   (key_inv_o),
    .inv_o       (inv_o),
    .round_o     (round_o),
    .rcon_o      (rcon_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_count = 0;
  int done_cyc = 0;
  logic [31:0] exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] mk(input logic busy, input logic ld, input logic rs,
                                     input logic ks, input logic [1:0] rt, input logic ki,
                                     input logic [3:0] rnd, input logic [7:0] rc,
                                     input logic dn, input logic ab);
    return {11'b0, busy, ld, rs, ks, rt, ki, rnd, rc, dn, ab};
  endfunction

  function automatic logic [31:0] pack_out();
    return {11'b0, busy_o, load_o, round_step_o, key_step_o, round_type_o, key_inv_o,
            round_o, rcon_o, done_o, aborted_o};
  endfunction

  // Expected event sequence for one full operation with NR = 10.
  task automatic push_op(input bit dec);
    exp_q.push_back(mk(1, 1, 0, 0, 2'b00, 0, 4'd0, 8'h00, 0, 0));
    if (dec) begin
      for (int k = 1; k <= 10; k++)
        exp_q.push_back(mk(1, 0, 0, 1, 2'b00, 0, 4'(k), RCON_TAB[k], 0, 0));
    end
    exp_q.push_back(mk(1, 0, 1, 0, 2'b00, 0, dec ? 4'd10 : 4'd0, 8'h00, 0, 0));
    if (dec) begin
      for (int r = 9; r >= 1; r--)
        exp_q.push_back(mk(1, 0, 1, 1, 2'b01, 1, 4'(r), RCON_TAB[r+1], 0, 0));
      exp_q.push_back(mk(1, 0, 1, 1, 2'b10, 1, 4'd0, RCON_TAB[1], 0, 0));
    end else begin
      for (int r = 1; r <= 9; r++)
        exp_q.push_back(mk(1, 0, 1, 1, 2'b01, 0, 4'(r), RCON_TAB[r], 0, 0));
      exp_q.push_back(mk(1, 0, 1, 1, 2'b10, 0, 4'd10, RCON_TAB[10], 0, 0));
    end
    exp_q.push_back(mk(1, 0, 0, 0, 2'b00, 0, 4'd0, 8'h00, 1, 0));
  endtask

  logic [31:0] prev_vec = '0;
  logic        prev_stall = 1'b0;

  always @(negedge clk) begin
    logic [31:0] cur;
    logic [31:0] e;
    logic        stall, evt;
    if (rst_n) begin
      cur   = pack_out();
      stall = (round_step_o || key_step_o) && !dp_ready_i;
      if (prev_stall) check_eq("stall_hold", cur, prev_vec);
      evt = load_o || done_o || aborted_o || ((round_step_o || key_step_o) && dp_ready_i);
      if (evt) begin
        $display("[%0d] txn load=%0b rs=%0b ks=%0b type=%0d round=%0d rcon=%02h kinv=%0b done=%0b aborted=%0b",
                 cyc, load_o, round_step_o, key_step_o, round_type_o, round_o, rcon_o,
                 key_inv_o, done_o, aborted_o);
        if (exp_q.size() == 0) begin
          check_eq("unexpected_event", cur, 32'h0);
        end else begin
          e = exp_q.pop_front();
          check_eq("scoreboard", cur, e);
        end
        if (done_o) begin
          done_count++;
          done_cyc = cyc;
        end
      end
      prev_stall = stall;
      prev_vec   = cur;
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic start_op(input bit dec, output int s_cyc);
    push_op(dec);
    start_i   = 1'b1;
    decrypt_i = dec;
    s_cyc     = cyc;
    @(posedge clk); #1;
    start_i   = 1'b0;
    decrypt_i = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int s_cyc, input int lat);
    int prev;
    prev = done_count;
    for (int i = 0; i < 100 && done_count == prev; i++) begin
      @(posedge clk); #1;
    end
    check_eq({tag, "_done_seen"}, 32'(done_count - prev), 32'd1);
    check_eq({tag, "_latency"}, 32'(done_cyc - s_cyc), 32'(lat));
  endtask

  task automatic wait_step(input string tag, input logic rs, input logic [1:0] rt, input int r);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(posedge clk); #1;
      if (round_step_o == rs && key_step_o && round_type_o == rt && round_o == 4'(r))
        found = 1'b1;
    end
    check_eq({tag, "_reached"}, 32'(found), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int s;
    int dc;
    rst_n = 1'b0; start_i = 1'b0; decrypt_i = 1'b0; abort_i = 1'b0; dp_ready_i = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_eq("reset_outputs", pack_out(), 32'h0);
    check_eq("reset_inv", 32'(inv_o), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Plain encrypt and decrypt.
    start_op(0, s);
    wait_done("enc", s, 13);
    check_eq("enc_inv", 32'(inv_o), 32'd0);
    @(posedge clk); #1;
    start_op(1, s);
    wait_done("dec", s, 23);
    check_eq("dec_inv_held", 32'(inv_o), 32'd1);
    @(posedge clk); #1;

    // Backpressure: three stalled cycles in round 4.
    start_op(0, s);
    wait_step("bp", 1'b1, 2'b01, 4);
    dp_ready_i = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    check_eq("bp_round_held", 32'(round_o), 32'd4);
    dp_ready_i = 1'b1;
    wait_done("bp", s, 16);
    @(posedge clk); #1;

    // Abort in round 5, then a normal encrypt.
    start_op(0, s);
    wait_step("abort", 1'b1, 2'b01, 5);
    abort_i = 1'b1;
    @(negedge clk); #1;
    exp_q.delete();
    exp_q.push_back(mk(0, 0, 0, 0, 2'b00, 0, 4'd0, 8'h00, 0, 1));
    @(posedge clk); #1;
    abort_i = 1'b0;
    check_eq("abort_pulse", 32'(aborted_o), 32'd1);
    check_eq("abort_busy", 32'(busy_o), 32'd0);
    dc = done_count;
    repeat (4) begin
      @(posedge clk); #1;
    end
    check_eq("abort_no_done", 32'(done_count - dc), 32'd0);
    check_eq("abort_pulse_end", 32'(aborted_o), 32'd0);
    start_op(0, s);
    wait_done("post_abort", s, 13);
    @(posedge clk); #1;

    // Start together with abort in IDLE is accepted.
    abort_i = 1'b1;
    start_op(0, s);
    abort_i = 1'b0;
    check_eq("idle_abort_load", 32'(load_o), 32'd1);
    wait_done("idle_abort", s, 13);
    @(posedge clk); #1;

    // A start pulse mid-operation is ignored.
    dc = done_count;
    start_op(0, s);
    repeat (4) begin
      @(posedge clk); #1;
    end
    start_i = 1'b1; decrypt_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0; decrypt_i = 1'b0;
    wait_done("midstart", s, 13);
    check_eq("midstart_inv", 32'(inv_o), 32'd0);
    repeat (5) begin
      @(posedge clk); #1;
    end
    check_eq("midstart_single_done", 32'(done_count - dc), 32'd1);

    // Back-to-back: start held through DONE is taken only in the following IDLE cycle.
    start_op(0, s);
    for (int i = 0; i < 100 && !done_o; i++) begin
      @(posedge clk); #1;
    end
    check_eq("b2b_first_done", 32'(done_o), 32'd1);
    push_op(0);
    start_i = 1'b1;
    @(posedge clk); #1;
    check_eq("b2b_idle_busy", 32'(busy_o), 32'd0);
    s = cyc;
    @(posedge clk); #1;
    start_i = 1'b0;
    wait_done("b2b", s, 13);
    @(posedge clk); #1;

    // Asynchronous reset during key expansion.
    start_op(1, s);
    wait_step("rst", 1'b0, 2'b00, 3);
    #1;
    rst_n = 1'b0;
    #1;
    check_eq("async_reset_outputs", pack_out(), 32'h0);
    check_eq("async_reset_inv", 32'(inv_o), 32'd0);
    exp_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_eq("post_reset_busy", 32'(busy_o), 32'd0);
    start_op(0, s);
    wait_done("post_reset", s, 13);
    repeat (3) begin
      @(posedge clk); #1;
    end
    check_eq("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/aes_round_sequencer.md
Name: aes_round_sequencer

Overview:
- Control FSM that sequences an iterative AES-128 round datapath (state register, S-box/MixColumns logic, on-the-fly key schedule) on behalf of the wishbone-facing AES control block.
- Takes a start/mode request, issues load, key-schedule and round strobes with round index and rcon, honours a datapath ready handshake, and reports busy/done/aborted.
- Contains no datapath itself.

Parameters:
- NR, 10, number of AES rounds; legal range 2..10.
- CW, 4, round counter width; must satisfy 2^CW > NR.

Ports:
- wb_clk_i  input  1  system clock; all state changes on its rising edge.
- wb_rst_ni  input  1  asynchronous, active-low reset.
- start_i  input  1  request a block operation; sampled only in IDLE.
- decrypt_i  input  1  mode; sampled together with start_i; 1 = decrypt.
- abort_i  input  1  cancel the current operation.
- dp_ready_i  input  1  datapath has completed the currently presented step.
- busy_o  output  1  high in every state except IDLE.
- done_o  output  1  one-cycle pulse when an operation completes.
- aborted_o  output  1  one-cycle pulse when an abort is taken.
- load_o  output  1  one-cycle strobe: load the input block and cipher key into the datapath.
- round_step_o  output  1  a round operation is presented.
- round_type_o  output  2  00 initial AddRoundKey, 01 full round, 10 final round (no MixColumns).
- key_step_o  output  1  a key-schedule step is presented.
- key_inv_o  output  1  key step direction; 1 = inverse.
- inv_o  output  1  latched decrypt mode; selects inverse round functions.
- round_o  output  CW  current round index.
- rcon_o  output  8  round constant for the presented key step.

Behaviour:
- Reset: asynchronous on wb_rst_ni low. State goes to IDLE and all outputs go to 0; latched mode is cleared.
- States: IDLE, LOAD, KEYEXP, INIT, ROUND, FINAL, DONE.
- Step handshake: in KEYEXP, INIT, ROUND and FINAL the step outputs are held steady. A step completes in a cycle where dp_ready_i = 1; the FSM advances at the next edge. While dp_ready_i = 0 the FSM waits indefinitely.
- IDLE: start_i = 1 latches decrypt_i into inv_o and moves to LOAD.
- LOAD: load_o = 1 for exactly one cycle, with no handshake. Next state is KEYEXP if decrypting, otherwise INIT.
- KEYEXP (decrypt only): key_step_o = 1, key_inv_o = 0, round_o = k, rcon_o = rcon[k] for k = 1..NR. k increments on each completion. Completion at k = NR goes to INIT.
- INIT: round_step_o = 1, round_type_o = 00. round_o = 0 when encrypting, NR when decrypting. key_step_o = 0. Completion goes to ROUND.
- ROUND: round_step_o = 1, key_step_o = 1, round_type_o = 01.
  - Encrypt: round_o = 1..NR-1, key_inv_o = 0, rcon_o = rcon[round_o].
  - Decrypt: round_o = NR-1 down to 1, key_inv_o = 1, rcon_o = rcon[round_o+1].
  - Completion of the last index goes to FINAL.
- FINAL: round_step_o = 1, key_step_o = 1, round_type_o = 10.
  - Encrypt: round_o = NR, rcon_o = rcon[NR].
  - Decrypt: round_o = 0, key_inv_o = 1, rcon_o = rcon[1].
  - Completion goes to DONE.
- DONE: done_o = 1 for one cycle, then IDLE. inv_o holds its value until the next start.
- rcon table, index 1..10: 01, 02, 04, 08, 10, 20, 40, 80, 1B, 36. rcon_o = 00 whenever key_step_o = 0.
- Inactive strobes and fields: round_step_o and key_step_o are 0 and round_type_o = 00 outside the states listed above. key_inv_o = 0 whenever key_step_o = 0.
- Latency with dp_ready_i tied 1 and start_i in cycle T:
  - load_o in T+1, INIT in T+2.
  - Encrypt: ROUND T+3..T+NR+1, FINAL T+NR+2, done_o T+NR+3 (T+13 for NR=10).
  - Decrypt: add NR cycles (done_o at T+23 for NR=10).
- abort_i in any non-IDLE state:
  - Takes priority over dp_ready_i.
  - Next cycle: state IDLE, all strobes 0, aborted_o = 1 for one cycle, no done_o.
  - Abort in DONE still pulses aborted_o and suppresses done_o only if taken before DONE is entered; abort sampled while in DONE is ignored.
  - abort_i in IDLE is ignored, including when start_i is high in the same cycle; the start is accepted.
- start_i while busy_o = 1 is ignored, with no queuing.
- Asynchronous reset mid-operation: behaves exactly as reset, with no done_o or aborted_o pulse.
- Back-to-back: start_i high in the DONE cycle is ignored. A start in the following IDLE cycle is accepted.

Test Plan:
- Encrypt, NR=10, dp_ready_i=1, start in cycle 0:
  - load_o in cycle 1; round_o 0,1..9,10 in cycles 2..12.
  - rcon_o 00, 01..1B, 36; round_type_o 00, 01×9, 10.
  - done_o only in cycle 13; busy_o high cycles 1..13.
- Decrypt, dp_ready_i=1:
  - KEYEXP round_o 1..10, rcon 01..36, key_inv_o=0.
  - INIT round_o=10; ROUND round_o 9..1 with rcon 36..02 and key_inv_o=1.
  - FINAL round_o=0, rcon 01; done_o at cycle 23; inv_o=1.
- Backpressure: dp_ready_i low for 3 cycles in ROUND round 4 -> outputs stable over those cycles, round_o stays 4; total encrypt done_o delayed exactly 3 cycles (cycle 16).
- Abort in ROUND round 5 -> next cycle IDLE, aborted_o=1 one cycle, busy_o=0, no done_o; a following start completes a normal encrypt.
- start_i and abort_i together in IDLE -> start accepted, load_o next cycle. start_i pulsed mid-operation -> ignored, single done_o.
- wb_rst_ni low during KEYEXP -> all outputs 0 immediately (asynchronous, no clock edge needed); after release the FSM is in IDLE and runs a fresh encrypt correctly.
